// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: RAM handshake state, word type, arbiter FSM
// state and grant-owner select.
package ram_arbiter_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arbstate_t;
  typedef enum logic {ARB_I, ARB_D} arbsel_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the I-fetch, D-port and RAM-side signals around the arbiter.
// slave = arbiter view, master = environment (requesters + RAM) view.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = WORD_W
) ();
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [ADDR_W-1:0] iload;
  logic              iwait;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic [ADDR_W-1:0] dload;
  logic              dwait;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  ramstate_t         ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between I fetch and D port. Fixed D priority with an I
// starvation guard; define ARB_RR_EN for round-robin on contention instead.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = WORD_W
) (
  input logic         CLK,
  input logic         RST,
  ram_arbiter_if.slave bus
);

  arbstate_t state, nstate;
  arbsel_t   pick;
  logic      dreq;

  assign dreq = bus.dREN | bus.dWEN;

`ifdef ARB_RR_EN
  arbsel_t lastg;

  always_comb pick = (lastg == ARB_I) ? ARB_D : ARB_I;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                   lastg <= ARB_I;
    else if (state == IDLE && nstate == GNT_I) lastg <= ARB_I;
    else if (state == IDLE && nstate == GNT_D) lastg <= ARB_D;
  end
`else
  logic [2:0] scnt;

  always_comb pick = (int'(scnt) == STARVE_MAX) ? ARB_I : ARB_D;

  // scnt counts I losses only while I keeps asking; any I grant or idle I resets it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) scnt <= 3'd0;
    else if (state == IDLE) begin
      if (!bus.iREN || nstate == GNT_I) scnt <= 3'd0;
      else if (nstate == GNT_D)         scnt <= scnt + 3'd1;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nstate;
  end

  // Every grant returns to IDLE so the RAM always sees enables drop between accesses
  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (bus.iREN && dreq) nstate = (pick == ARB_I) ? GNT_I : GNT_D;
        else if (dreq)        nstate = GNT_D;
        else if (bus.iREN)    nstate = GNT_I;
      end
      GNT_I:   if (!bus.iREN || bus.ramstate == ACCESS) nstate = IDLE;
      GNT_D:   if (!dreq || bus.ramstate == ACCESS)     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = {ADDR_W{1'b0}};
    bus.ramstore = {ADDR_W{1'b0}};
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = bus.ramload;
    bus.dload    = bus.ramload;
    case (state)
      GNT_I: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        bus.iwait   = (bus.ramstate != ACCESS);
      end
      GNT_D: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dwait    = (bus.ramstate != ACCESS);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural variable-latency RAM.
// Build with ARB_RR_EN defined to check the round-robin variant.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int SM = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ram_arbiter_if #(.ADDR_W(32)) bus ();
  ram_arbiter #(.STARVE_MAX(SM), .ADDR_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0;
  int errors = 0;

  // RAM model: ACCESS on the lat-th consecutive enabled cycle at a stable address
  int    lat = 3;
  logic  force_err = 1'b0;
  logic  force_ld = 1'b0;
  word_t force_val = '0;
  int    cnt_q = 0;
  int    cur;
  logic  prev_en = 1'b0, prev_acc = 1'b0;
  word_t paddr = '0;
  logic  en;

  function automatic word_t pat(input word_t a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign en = bus.ramREN | bus.ramWEN;
  assign bus.ramload = force_ld ? force_val : pat(bus.ramaddr);

  always_comb begin
    cur = (en && prev_en && !prev_acc && bus.ramaddr == paddr) ? cnt_q + 1 : 0;
    if (!en)              bus.ramstate = FREE;
    else if (force_err)   bus.ramstate = ERROR;
    else if (cur >= lat-1) bus.ramstate = ACCESS;
    else                  bus.ramstate = BUSY;
  end

  always @(posedge CLK) begin
    prev_en  <= en;
    paddr    <= bus.ramaddr;
    cnt_q    <= cur;
    prev_acc <= (bus.ramstate == ACCESS);
  end

  // Monitor: grant owners (D addresses have bit 31 set), completions, IDLE-gap rule
  arbsel_t gq[$];
  int   i_done = 0, d_done = 0, gap_viol = 0;
  logic prev_done = 1'b0, pen = 1'b0;
  always @(negedge CLK) begin
    if (en && !pen) gq.push_back(bus.ramaddr[31] ? ARB_D : ARB_I);
    if (en && prev_done) gap_viol <= gap_viol + 1;
    if (!bus.iwait) i_done <= i_done + 1;
    if (!bus.dwait) d_done <= d_done + 1;
    prev_done <= !bus.iwait || !bus.dwait;
    pen       <= en;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin errors++;
      $display("FAIL reset_en got REN=%b WEN=%b exp 0 0", bus.ramREN, bus.ramWEN); end
    checks++; if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin errors++;
      $display("FAIL reset_bus got addr=%h store=%h exp 0 0", bus.ramaddr, bus.ramstore); end
    checks++; if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin errors++;
      $display("FAIL reset_wait got i=%b d=%b exp 1 1", bus.iwait, bus.dwait); end
    checks++; if (bus.iload !== pat(32'h0) || bus.dload !== pat(32'h0)) begin errors++;
      $display("FAIL reset_load got i=%h d=%h exp %h", bus.iload, bus.dload, pat(32'h0)); end
    // reset in the middle of a D grant
    lat = 100; bus.dREN = 1'b1; bus.daddr = 32'h8000_0010;
    tick();
    checks++; if (bus.ramREN !== 1'b1) begin errors++;
      $display("FAIL pre_reset_grant got ramREN=%b exp 1", bus.ramREN); end
    #2 RST = 1'b1; #1;
    checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1) begin errors++;
      $display("FAIL async_reset got REN=%b WEN=%b dwait=%b exp 0 0 1", bus.ramREN, bus.ramWEN, bus.dwait); end
    tick(); RST = 1'b0; #1;
    checks++; if (bus.ramREN !== 1'b0) begin errors++;
      $display("FAIL post_reset_idle got ramREN=%b exp 0", bus.ramREN); end
    tick();
    checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h8000_0010) begin errors++;
      $display("FAIL post_reset_regrant got REN=%b addr=%h exp 1 80000010", bus.ramREN, bus.ramaddr); end
    idle_inputs(); tick(); lat = 3;
  endtask

  task automatic test_lone_read();
    int cyc;
    lat = 6; force_ld = 1'b1; force_val = 32'h1234;
    bus.iREN = 1'b1; bus.iaddr = 32'h40; #1;
    checks++; if (bus.iwait !== 1'b1) begin errors++;
      $display("FAIL read_req_cycle got iwait=%b exp 1", bus.iwait); end
    tick(); cyc = 1;
    checks++; if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h40) begin errors++;
      $display("FAIL read_grant got REN=%b WEN=%b addr=%h exp 1 0 40", bus.ramREN, bus.ramWEN, bus.ramaddr); end
    while (bus.iwait && cyc < 50) begin tick(); cyc++; end
    checks++; if (cyc !== 6) begin errors++;
      $display("FAIL read_latency got %0d cycles exp 6", cyc); end
    checks++; if (bus.iload !== 32'h1234) begin errors++;
      $display("FAIL read_data got %h exp 1234", bus.iload); end
    bus.iREN = 1'b0; tick();
    checks++; if (bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin errors++;
      $display("FAIL read_after got iwait=%b REN=%b exp 1 0", bus.iwait, bus.ramREN); end
    force_ld = 1'b0; lat = 3;
  endtask

  task automatic test_contention();
    int cyc;
    do_reset(); lat = 3;
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dWEN = 1'b1; bus.daddr = 32'h8000_0080; bus.dstore = 32'hDEAD;
    tick(); cyc = 1;
    checks++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramstore !== 32'hDEAD || bus.ramaddr !== 32'h8000_0080) begin errors++;
      $display("FAIL cont_d_first got WEN=%b REN=%b store=%h addr=%h", bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr); end
    while (bus.dwait && cyc < 50) begin tick(); cyc++; end
    checks++; if (cyc !== 3 || bus.iwait !== 1'b1) begin errors++;
      $display("FAIL cont_d_done got cyc=%0d iwait=%b exp 3 1", cyc, bus.iwait); end
    bus.dWEN = 1'b0; tick();
    checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin errors++;
      $display("FAIL cont_gap got REN=%b WEN=%b exp 0 0", bus.ramREN, bus.ramWEN); end
    tick(); cyc = 1;
    checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h44) begin errors++;
      $display("FAIL cont_i_next got REN=%b addr=%h exp 1 44", bus.ramREN, bus.ramaddr); end
    while (bus.iwait && cyc < 50) begin tick(); cyc++; end
    checks++; if (bus.iwait !== 1'b0 || bus.iload !== pat(32'h44)) begin errors++;
      $display("FAIL cont_i_done got iwait=%b load=%h exp 0 %h", bus.iwait, bus.iload, pat(32'h44)); end
    idle_inputs(); tick();
  endtask

  task automatic test_starvation();
    int cyc;
    arbsel_t exp;
    do_reset(); lat = int'($urandom_range(1, 3));
    gq.delete();
    bus.iREN = 1'b1; bus.iaddr = 32'h48;
    bus.dREN = 1'b1; bus.daddr = 32'h8000_0100;
    cyc = 0;
    while (gq.size() < 10 && cyc < 400) begin tick(); cyc++; end
    idle_inputs(); tick(); tick();
    checks++; if (gq.size() < 10) begin errors++;
      $display("FAIL starve_timeout got %0d grants exp 10", gq.size()); end
    for (int k = 0; k < 10 && k < gq.size(); k++) begin
`ifdef ARB_RR_EN
      exp = (k % 2 == 1) ? ARB_I : ARB_D;
`else
      exp = (k % (SM + 1) == SM) ? ARB_I : ARB_D;
`endif
      checks++; if (gq[k] !== exp) begin errors++;
        $display("FAIL starve_grant%0d got %s exp %s", k, gq[k].name(), exp.name()); end
    end
  endtask

  task automatic test_abort_error();
    int cyc, d0;
    logic bad;
    do_reset(); lat = 100;
    bus.dREN = 1'b1; bus.daddr = 32'h8000_0200;
    tick(); d0 = d_done;
    checks++; if (bus.ramREN !== 1'b1) begin errors++;
      $display("FAIL abort_grant got REN=%b exp 1", bus.ramREN); end
    tick();
    bus.dREN = 1'b0; bus.iREN = 1'b1; bus.iaddr = 32'h4C;
    tick();
    checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1) begin errors++;
      $display("FAIL abort_idle got REN=%b WEN=%b dwait=%b exp 0 0 1", bus.ramREN, bus.ramWEN, bus.dwait); end
    tick();
    checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h4C || d_done !== d0) begin errors++;
      $display("FAIL abort_i_grant got REN=%b addr=%h dcompl=%0d exp 1 4c 0", bus.ramREN, bus.ramaddr, d_done - d0); end
    // ERROR must behave as BUSY; then a mid-grant address change restarts latency
    lat = 4; force_err = 1'b1; bad = 1'b0;
    for (int k = 0; k < 5; k++) begin tick(); if (bus.iwait !== 1'b1) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin errors++;
      $display("FAIL error_as_busy got early completion exp none"); end
    force_err = 1'b0; bus.iaddr = 32'h50; #1;
    checks++; if (bus.ramaddr !== 32'h50 || bus.iwait !== 1'b1) begin errors++;
      $display("FAIL addr_passthru got addr=%h iwait=%b exp 50 1", bus.ramaddr, bus.iwait); end
    cyc = 0;
    while (bus.iwait && cyc < 50) begin tick(); cyc++; end
    checks++; if (cyc !== 3 || bus.iload !== pat(32'h50)) begin errors++;
      $display("FAIL addr_restart got cyc=%0d load=%h exp 3 %h", cyc, bus.iload, pat(32'h50)); end
    idle_inputs(); tick(); lat = 3;
  endtask

  task automatic test_random();
    logic    wi, wd, wr, first_seen;
    int      cyc;
    arbsel_t last_owner, exp_first, first;
    do_reset(); last_owner = ARB_I;
    for (int it = 0; it < 40; it++) begin
      wi = 1'($urandom_range(0, 1)); wd = 1'($urandom_range(0, 1));
      if (!wi && !wd) wd = 1'b1;
      wr = 1'($urandom_range(0, 1));
      lat = int'($urandom_range(1, 5));
      bus.iREN = wi; bus.iaddr = $urandom & 32'h0000_0FFC;
      bus.dWEN = wd & wr; bus.dREN = wd & (wr ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.daddr = 32'h8000_0000 | ($urandom & 32'h0000_0FFC); bus.dstore = $urandom;
`ifdef ARB_RR_EN
      exp_first = (last_owner == ARB_I) ? ARB_D : ARB_I;
`else
      exp_first = ARB_D;
`endif
      first_seen = 1'b0; first = ARB_I; cyc = 0;
      while ((bus.iREN || bus.dREN || bus.dWEN) && cyc < 100) begin
        tick(); cyc++;
        if (!bus.iwait) begin
          checks++; if (bus.iload !== pat(bus.iaddr)) begin errors++;
            $display("FAIL rand_iload it=%0d got %h exp %h", it, bus.iload, pat(bus.iaddr)); end
          if (!first_seen) begin first = ARB_I; first_seen = 1'b1; end
          last_owner = ARB_I; bus.iREN = 1'b0;
        end
        if (!bus.dwait) begin
          if (wr) begin
            checks++; if (bus.ramWEN !== 1'b1 || bus.ramstore !== bus.dstore || bus.ramaddr !== bus.daddr) begin errors++;
              $display("FAIL rand_dwrite it=%0d got WEN=%b store=%h addr=%h", it, bus.ramWEN, bus.ramstore, bus.ramaddr); end
          end else begin
            checks++; if (bus.dload !== pat(bus.daddr) || bus.ramREN !== 1'b1) begin errors++;
              $display("FAIL rand_dload it=%0d got %h exp %h", it, bus.dload, pat(bus.daddr)); end
          end
          if (!first_seen) begin first = ARB_D; first_seen = 1'b1; end
          last_owner = ARB_D; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        end
      end
      checks++; if (cyc >= 100) begin errors++;
        $display("FAIL rand_timeout it=%0d got pending exp done", it); end
      if (wi && wd) begin
        checks++; if (first !== exp_first) begin errors++;
          $display("FAIL rand_order it=%0d got %s exp %s", it, first.name(), exp_first.name()); end
      end
      idle_inputs();
      repeat ($urandom_range(1, 2)) tick();
    end
    checks++; if (gap_viol !== 0) begin errors++;
      $display("FAIL idle_gap got %0d violations exp 0", gap_viol); end
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_lone_read();
    test_contention();
    test_starvation();
    test_abort_error();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
